// File: rtl/combination_lock_if.sv
// Signal bundle between the combination-lock controller, the keypad front end,
// the single-digit dial comparator and the status outputs.
interface combination_lock_if #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned MAX_ATTEMPTS = 3
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

  logic [4*NUM_DIGITS-1:0] combination;
  logic [3:0]              digit_guess;
  logic                    enter;
  logic                    clear;
  logic                    relock;
  logic                    digit_found_flag;
  logic [3:0]              dial_digit;
  logic [3:0]              dial_guess;
  logic [IDX_W-1:0]        digit_index;
  logic [ATT_W-1:0]        attempts_left;
  logic                    unlocked;
  logic                    error;
  logic                    locked_out;

  modport master (
    output combination, digit_guess, enter, clear, relock, digit_found_flag,
    input  dial_digit, dial_guess, digit_index, attempts_left, unlocked, error, locked_out
  );

  modport slave (
    input  combination, digit_guess, enter, clear, relock, digit_found_flag,
    output dial_digit, dial_guess, digit_index, attempts_left, unlocked, error, locked_out
  );
endinterface

// File: rtl/combination_lock_controller.sv
// Digit-by-digit combination entry sequencer: feeds the dial comparator, defers the
// pass/fail verdict until the last digit, and counts failures into a timed lockout.
module combination_lock_controller #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
  input logic               clk,
  input logic               rst,
  combination_lock_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_VERDICT,
    S_FAIL,
    S_UNLOCKED,
    S_LOCKOUT
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       guess_q, guess_d;
  logic             mismatch_q, mismatch_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ENTRY;
      idx_q      <= '0;
      guess_q    <= '0;
      mismatch_q <= 1'b0;
      att_q      <= ATT_MAX;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      guess_q    <= guess_d;
      mismatch_q <= mismatch_d;
      att_q      <= att_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    guess_d    = guess_q;
    mismatch_d = mismatch_q;
    att_d      = att_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_ENTRY: begin
        if (bus.clear) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
        end else if (bus.enter) begin
          guess_d = bus.digit_guess;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (bus.clear) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
          state_d    = S_ENTRY;
        end else begin
          // Mismatch accumulates silently; only VERDICT acts on it.
          mismatch_d = mismatch_q | ~bus.digit_found_flag;
          if (idx_q == LAST_IDX) begin
            state_d = S_VERDICT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ENTRY;
          end
        end
      end

      S_VERDICT: begin
        idx_d      = '0;
        mismatch_d = 1'b0;
        if (!mismatch_q) begin
          att_d   = ATT_MAX;
          state_d = S_UNLOCKED;
        end else if (att_q <= ATT_W'(1)) begin
          att_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_LOCKOUT;
        end else begin
          att_d   = att_q - 1'b1;
          state_d = S_FAIL;
        end
      end

      S_FAIL: state_d = S_ENTRY;

      S_UNLOCKED: begin
        if (bus.relock) state_d = S_ENTRY;
      end

      S_LOCKOUT: begin
        if (cnt_q == '0) begin
          att_d   = ATT_MAX;
          state_d = S_ENTRY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_ENTRY;
    endcase
  end

  always_comb begin
    bus.dial_digit = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) bus.dial_digit = bus.combination[4*k +: 4];
    end
  end

  assign bus.dial_guess    = guess_q;
  assign bus.digit_index   = idx_q;
  assign bus.attempts_left = att_q;
  assign bus.unlocked      = (state_q == S_UNLOCKED);
  assign bus.error         = (state_q == S_FAIL);
  assign bus.locked_out    = (state_q == S_LOCKOUT);
endmodule

// File: doc/combination_lock_controller.md
# combination_lock_controller

Sequencing controller for the combination-lock datapath. It accepts one guessed digit per `enter` pulse and presents each digit, with the matching stored combination digit, to the single-digit dial comparator. It samples the comparator's match flag and issues a pass or fail verdict only after all digits are entered, so a wrong digit is never revealed early. It also counts failed attempts and enforces a timed lockout. It sits between the keypad/switch debouncing logic and the lock status LEDs/display.

## Interface
Parameters:
- `NUM_DIGITS`, 4, digits per combination (≥2)
- `MAX_ATTEMPTS`, 3, failed attempts allowed before lockout (≥1)
- `LOCKOUT_CYCLES`, 100_000_000, clock cycles spent in lockout (≥1)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `combination`  in  4*NUM_DIGITS  stored code; digit k = `combination[4k+3:4k]`, digit 0 entered first
- `digit_guess`  in  4  user digit, sampled on `enter`
- `enter`  in  1  one-cycle pulse (pre-debounced) to submit `digit_guess`
- `clear`  in  1  one-cycle pulse to abandon the current entry
- `relock`  in  1  one-cycle pulse to leave UNLOCKED
- `digit_found_flag`  in  1  comparator result for the current `dial_digit`/`dial_guess`
- `dial_digit`  out  4  `combination` digit selected by `digit_index`, to comparator
- `dial_guess`  out  4  registered guess, to comparator
- `digit_index`  out  clog2(NUM_DIGITS)  digit position currently being entered
- `attempts_left`  out  clog2(MAX_ATTEMPTS+1)  remaining attempts
- `unlocked`  out  1  high while in UNLOCKED
- `error`  out  1  one-cycle pulse on a failed attempt that does not trigger lockout
- `locked_out`  out  1  high while in LOCKOUT

## Operation
States:
- **ENTRY**
  - On `enter`: latch `digit_guess` into `dial_guess`, go to CHECK.
  - On `clear`: set `digit_index`=0 and `mismatch`=0, stay in ENTRY. No attempt is consumed.
- **CHECK** (always 1 cycle)
  - Update `mismatch |= ~digit_found_flag`.
  - If `digit_index`==NUM_DIGITS-1, go to VERDICT.
  - Otherwise increment `digit_index` and go to ENTRY.
  - `clear` in this state: abandon as in ENTRY and go to ENTRY. The flag is discarded.
- **VERDICT** (always 1 cycle)
  - Next-mismatch = `mismatch | ~flag` is evaluated in CHECK, so VERDICT uses the registered `mismatch`.
  - If `mismatch`=0: go to UNLOCKED and set `attempts_left`=MAX_ATTEMPTS.
  - Otherwise decrement `attempts_left`. If the result is 0, go to LOCKOUT; else go to FAIL.
  - In every case clear `digit_index` and `mismatch`.
- **FAIL** (always 1 cycle): `error`=1, then go to ENTRY.
- **UNLOCKED**: `unlocked`=1. On `relock`, go to ENTRY. `enter` and `clear` are ignored.
- **LOCKOUT**
  - `locked_out`=1. Load the counter with LOCKOUT_CYCLES-1 on entry and decrement it each cycle.
  - At 0, go to ENTRY and set `attempts_left`=MAX_ATTEMPTS.
  - `enter`, `clear` and `relock` are ignored.

Rules:
- `dial_digit` is a combinational mux of `combination` by the registered `digit_index`.
- `combination` must be stable during an attempt. If it changes mid-attempt, each digit is compared against the value present in its own CHECK cycle.
- `enter` and `clear` in the same cycle: `clear` wins.
- `enter` outside ENTRY is dropped; it is not queued.
- `relock` outside UNLOCKED is ignored.
- `rst` mid-attempt, including during LOCKOUT, returns all registers to their reset values. This also restores `attempts_left`.
- `attempts_left` never underflows and never exceeds MAX_ATTEMPTS.

## Timing
- Reset values:
  - State ENTRY.
  - `digit_index`=0, `dial_guess`=0, `mismatch`=0, lockout counter 0.
  - `attempts_left`=MAX_ATTEMPTS.
  - `unlocked`=0, `error`=0, `locked_out`=0.
- Per digit: `enter` in cycle N → `dial_guess` valid N+1 (CHECK; flag sampled at end of N+1) → `digit_index` advances at N+2.
- Last digit: `enter` at N → CHECK at N+1 → VERDICT at N+2 → `unlocked`, `error` or `locked_out` first high at N+3.
- Minimum spacing between accepted `enter` pulses is 2 cycles. An `enter` during CHECK is dropped.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. `locked_out` falls and ENTRY resumes on the next cycle.
- All outputs are registered or derived from registered state. No input-to-output combinational paths exist except `dial_digit` ← `combination`.

## Test plan
Defaults: NUM_DIGITS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8, `combination`=16'h4321 (entry order 1,2,3,4). The bench models the comparator.

- **Correct code:** enter 1,2,3,4 with 3-cycle spacing → `unlocked`=1 three cycles after the 4th `enter`; `attempts_left`=3; `error` never pulses. `relock` → ENTRY, `unlocked`=0.
- **Silent wrong digit:** enter 1,9,3,4 → no `error` until after the 4th digit; then a single 1-cycle `error` pulse, `attempts_left`=2, `digit_index`=0.
- **Lockout:** three wrong codes → `error` pulses twice, then `locked_out`=1 for exactly 8 cycles with `attempts_left`=0. An `enter` during lockout has no effect. After expiry `attempts_left`=3 and a correct code unlocks.
- **Clear:** enter 1,2, then `clear`, then enter 1,2,3,4 → unlocks and `attempts_left` stays 3. `enter` and `clear` in the same cycle → `digit_index` returns to 0 and `dial_guess` is unchanged.
- **Dropped enter:** `enter` pulses on back-to-back cycles → second pulse dropped; `digit_index` advances by 1 only.
- **Reset mid-attempt:** `rst` during LOCKOUT and during digit 3 → all outputs at reset values the next cycle; `attempts_left`=3.
